// File: rtl/store_commit_sequencer.sv
// Store commit sequencer: drains committed stores from the store-queue head into the
// single DCache write port and frees each head entry once its write has completed.
module store_commit_sequencer #(
    parameter int SQ_INDEX_WIDTH   = 4,
    parameter int COMMIT_NUM_WIDTH = 2,
    parameter int ADDR_WIDTH       = 32,
    parameter int BLOCK_WIDTH      = 64,
    parameter int RETRY_DELAY      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        commitStore,
    input  logic [COMMIT_NUM_WIDTH-1:0] commitStoreNum,
    input  logic                        storeQueueEmpty,
    input  logic [SQ_INDEX_WIDTH-1:0]   storeQueueHeadPtr,
    input  logic                        retiredStoreCondEnabled,
    input  logic [ADDR_WIDTH-1:0]       retiredStoreAddr,
    input  logic [BLOCK_WIDTH-1:0]      retiredStoreData,
    input  logic [BLOCK_WIDTH/8-1:0]    retiredStoreByteWE,
    input  logic                        retiredStoreUncachable,
    input  logic                        dcWriteBusy,
    input  logic                        dcWriteReqAck,
    input  logic                        dcWriteHit,
    output logic [SQ_INDEX_WIDTH-1:0]   retiredStoreQueuePtr,
    output logic                        dcWriteReq,
    output logic [ADDR_WIDTH-1:0]       dcWriteAddr,
    output logic [BLOCK_WIDTH-1:0]      dcWriteData,
    output logic [BLOCK_WIDTH/8-1:0]    dcWriteByteWE,
    output logic                        dcWriteUncachable,
    output logic                        releaseStoreQueueHead,
    output logic [COMMIT_NUM_WIDTH-1:0] releaseStoreQueueHeadEntryNum,
    output logic                        busyInRecovery
);

    localparam int PEND_W = SQ_INDEX_WIDTH + 1;
    localparam int CNT_W  = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        RETRY_WAIT = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t              state;
    logic [PEND_W-1:0]   pending;
    logic [PEND_W:0]     commit_add;
    logic [PEND_W:0]     pending_wide;
    logic [PEND_W-1:0]   pending_next;
    logic [CNT_W-1:0]    retry_cnt;

    // One extra bit so that overflow and underflow stay visible to the assertion.
    always_comb begin
        commit_add   = commitStore ? (PEND_W+1)'(commitStoreNum) : '0;
        pending_wide = {1'b0, pending} + commit_add - (PEND_W+1)'(releaseStoreQueueHead);
        pending_next = pending_wide[PEND_W-1:0];
    end

    assign retiredStoreQueuePtr          = storeQueueHeadPtr;
    assign releaseStoreQueueHeadEntryNum = COMMIT_NUM_WIDTH'(releaseStoreQueueHead);
    assign busyInRecovery                = (pending != '0) || (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            pending               <= '0;
            retry_cnt             <= '0;
            dcWriteReq            <= 1'b0;
            dcWriteAddr           <= '0;
            dcWriteData           <= '0;
            dcWriteByteWE         <= '0;
            dcWriteUncachable     <= 1'b0;
            releaseStoreQueueHead <= 1'b0;
        end else begin
            pending               <= pending_next;
            releaseStoreQueueHead <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending != '0 && !storeQueueEmpty) begin
                        if (!retiredStoreCondEnabled) begin
                            // Squashed conditional store: free the entry without a write.
                            state                 <= RELEASE;
                            releaseStoreQueueHead <= 1'b1;
                        end else begin
                            state             <= REQ;
                            dcWriteReq        <= 1'b1;
                            dcWriteAddr       <= retiredStoreAddr;
                            dcWriteData       <= retiredStoreData;
                            dcWriteByteWE     <= retiredStoreByteWE;
                            dcWriteUncachable <= retiredStoreUncachable;
                        end
                    end
                end
                REQ: begin
                    if (!dcWriteBusy && dcWriteReqAck) begin
                        dcWriteReq <= 1'b0;
                        if (dcWriteHit || dcWriteUncachable) begin
                            state                 <= RELEASE;
                            releaseStoreQueueHead <= 1'b1;
                        end else begin
                            state     <= RETRY_WAIT;
                            retry_cnt <= CNT_W'(RETRY_DELAY - 1);
                        end
                    end
                end
                RETRY_WAIT: begin
                    if (retry_cnt == '0) begin
                        state      <= REQ;
                        dcWriteReq <= 1'b1;
                    end else begin
                        retry_cnt <= retry_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pending_in_range: assert property (@(posedge clk) disable iff (!rst)
        pending_wide <= (PEND_W+1)'(2 ** SQ_INDEX_WIDTH));

    pending_has_entries: assert property (@(posedge clk) disable iff (!rst)
        (state == IDLE && pending != '0) |-> !storeQueueEmpty);

endmodule

// File: tb/tb_store_commit_sequencer.sv
// Directed bench for store_commit_sequencer with a small store-queue model and
// hand-driven DCache handshake.
module tb_store_commit_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        commitStore;
    logic [1:0]  commitStoreNum;
    logic        storeQueueEmpty;
    logic [3:0]  storeQueueHeadPtr;
    logic        retiredStoreCondEnabled;
    logic [31:0] retiredStoreAddr;
    logic [63:0] retiredStoreData;
    logic [7:0]  retiredStoreByteWE;
    logic        retiredStoreUncachable;
    logic        dcWriteBusy;
    logic        dcWriteReqAck;
    logic        dcWriteHit;
    logic [3:0]  retiredStoreQueuePtr;
    logic        dcWriteReq;
    logic [31:0] dcWriteAddr;
    logic [63:0] dcWriteData;
    logic [7:0]  dcWriteByteWE;
    logic        dcWriteUncachable;
    logic        releaseStoreQueueHead;
    logic [1:0]  releaseStoreQueueHeadEntryNum;
    logic        busyInRecovery;

    store_commit_sequencer dut (
        .clk                           (clk),
        .rst                           (rst),
        .commitStore                   (commitStore),
        .commitStoreNum                (commitStoreNum),
        .storeQueueEmpty               (storeQueueEmpty),
        .storeQueueHeadPtr             (storeQueueHeadPtr),
        .retiredStoreCondEnabled       (retiredStoreCondEnabled),
        .retiredStoreAddr              (retiredStoreAddr),
        .retiredStoreData              (retiredStoreData),
        .retiredStoreByteWE            (retiredStoreByteWE),
        .retiredStoreUncachable        (retiredStoreUncachable),
        .dcWriteBusy                   (dcWriteBusy),
        .dcWriteReqAck                 (dcWriteReqAck),
        .dcWriteHit                    (dcWriteHit),
        .retiredStoreQueuePtr          (retiredStoreQueuePtr),
        .dcWriteReq                    (dcWriteReq),
        .dcWriteAddr                   (dcWriteAddr),
        .dcWriteData                   (dcWriteData),
        .dcWriteByteWE                 (dcWriteByteWE),
        .dcWriteUncachable             (dcWriteUncachable),
        .releaseStoreQueueHead         (releaseStoreQueueHead),
        .releaseStoreQueueHeadEntryNum (releaseStoreQueueHeadEntryNum),
        .busyInRecovery                (busyInRecovery)
    );

    always #5 clk = ~clk;

    // Store-queue model: entries loaded by the stimulus, head advanced by release pulses.
    logic [31:0] e_addr [16];
    logic [63:0] e_data [16];
    logic [7:0]  e_we   [16];
    logic        e_cond [16];
    logic        e_unc  [16];
    logic [4:0]  sq_head = '0;
    logic [4:0]  sq_tail = '0;

    always @(posedge clk) begin
        if (releaseStoreQueueHead) sq_head <= sq_head + 5'd1;
    end

    assign storeQueueEmpty         = (sq_head == sq_tail);
    assign storeQueueHeadPtr       = sq_head[3:0];
    assign retiredStoreAddr        = e_addr[retiredStoreQueuePtr];
    assign retiredStoreData        = e_data[retiredStoreQueuePtr];
    assign retiredStoreByteWE      = e_we[retiredStoreQueuePtr];
    assign retiredStoreCondEnabled = e_cond[retiredStoreQueuePtr];
    assign retiredStoreUncachable  = e_unc[retiredStoreQueuePtr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [63:0] d, input logic [7:0] we,
                        input logic cond, input logic unc);
        e_addr[sq_tail[3:0]] = a;
        e_data[sq_tail[3:0]] = d;
        e_we[sq_tail[3:0]]   = we;
        e_cond[sq_tail[3:0]] = cond;
        e_unc[sq_tail[3:0]]  = unc;
        sq_tail = sq_tail + 5'd1;
    endtask

    task automatic commit(input logic [1:0] n);
        commitStore    = 1'b1;
        commitStoreNum = n;
        cyc();
        commitStore    = 1'b0;
        commitStoreNum = 2'd0;
    endtask

    task automatic wait_req(input string tag, output int waited);
        waited = 0;
        while (!dcWriteReq && waited < 12) begin
            cyc();
            waited++;
        end
        chk(tag, dcWriteReq, 1);
    endtask

    task automatic ack(input logic hit);
        dcWriteReqAck = 1'b1;
        dcWriteHit    = hit;
        cyc();
        dcWriteReqAck = 1'b0;
        dcWriteHit    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b0;
        commitStore = 1'b0;
        commitStoreNum = 2'd0;
        dcWriteBusy = 1'b0;
        dcWriteReqAck = 1'b0;
        dcWriteHit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e_addr[i] = '0; e_data[i] = '0; e_we[i] = '0; e_cond[i] = 1'b0; e_unc[i] = 1'b0;
        end
        repeat (2) cyc();
        chk("rst_req", dcWriteReq, 0);
        chk("rst_addr", dcWriteAddr, 0);
        chk("rst_data", dcWriteData, 0);
        chk("rst_we", dcWriteByteWE, 0);
        chk("rst_release", releaseStoreQueueHead, 0);
        chk("rst_entrynum", releaseStoreQueueHeadEntryNum, 0);
        chk("rst_busy", busyInRecovery, 0);
        rst = 1'b1;
        cyc();

        // Single hit: req at t+2, release at t+3, idle at t+4.
        push(32'h1000, 64'h1122_3344_5566_7788, 8'h0F, 1'b1, 1'b0);
        chk("t1_ptr", retiredStoreQueuePtr, 0);
        chk("t1_busy_t0", busyInRecovery, 0);
        commit(2'd1);
        chk("t1_req_t1", dcWriteReq, 0);
        chk("t1_busy_t1", busyInRecovery, 1);
        cyc();
        chk("t1_req_t2", dcWriteReq, 1);
        chk("t1_addr", dcWriteAddr, 64'h1000);
        chk("t1_data", dcWriteData, 64'h1122_3344_5566_7788);
        chk("t1_we", dcWriteByteWE, 8'h0F);
        chk("t1_unc", dcWriteUncachable, 0);
        ack(1'b1);
        chk("t1_release_t3", releaseStoreQueueHead, 1);
        chk("t1_entrynum_t3", releaseStoreQueueHeadEntryNum, 1);
        chk("t1_req_t3", dcWriteReq, 0);
        cyc();
        chk("t1_busy_t4", busyInRecovery, 0);
        chk("t1_release_t4", releaseStoreQueueHead, 0);
        chk("t1_entrynum_t4", releaseStoreQueueHeadEntryNum, 0);
        chk("t1_ptr_adv", retiredStoreQueuePtr, 1);

        // Batch of three in one commit: three writes, three single-entry releases.
        push(32'h2000, 64'hA0, 8'hFF, 1'b1, 1'b0);
        push(32'h2040, 64'hA1, 8'hFF, 1'b1, 1'b0);
        push(32'h2080, 64'hA2, 8'hFF, 1'b1, 1'b0);
        commit(2'd3);
        for (int i = 0; i < 3; i++) begin
            wait_req("batch_req", w);
            chk("batch_gap", w, (i == 0) ? 1 : 2);
            chk("batch_addr", dcWriteAddr, 64'h2000 + 64'(i * 64));
            chk("batch_data", dcWriteData, 64'hA0 + 64'(i));
            ack(1'b1);
            chk("batch_release", releaseStoreQueueHead, 1);
            chk("batch_entrynum", releaseStoreQueueHeadEntryNum, 1);
        end
        cyc();
        chk("batch_busy_end", busyInRecovery, 0);
        chk("batch_ptr", retiredStoreQueuePtr, 4);

        // Busy backpressure: request and fields held while the port is busy.
        push(32'h3000, 64'hDEAD_BEEF_0000_3000, 8'h3C, 1'b1, 1'b0);
        commit(2'd1);
        dcWriteBusy = 1'b1;
        wait_req("bp_req", w);
        for (int k = 0; k < 5; k++) begin
            chk("bp_req_held", dcWriteReq, 1);
            chk("bp_addr_held", dcWriteAddr, 64'h3000);
            chk("bp_data_held", dcWriteData, 64'hDEAD_BEEF_0000_3000);
            chk("bp_no_release", releaseStoreQueueHead, 0);
            cyc();
        end
        dcWriteBusy = 1'b0;
        chk("bp_req_after", dcWriteReq, 1);
        ack(1'b1);
        chk("bp_release", releaseStoreQueueHead, 1);
        cyc();
        chk("bp_busy_end", busyInRecovery, 0);

        // Miss: request drops for four cycles, then identical re-request.
        push(32'h4000, 64'h4444_5555_6666_7777, 8'hF0, 1'b1, 1'b0);
        commit(2'd1);
        wait_req("miss_req", w);
        ack(1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("miss_req_low", dcWriteReq, 0);
            chk("miss_no_release", releaseStoreQueueHead, 0);
            cyc();
        end
        chk("miss_rereq", dcWriteReq, 1);
        chk("miss_addr", dcWriteAddr, 64'h4000);
        chk("miss_data", dcWriteData, 64'h4444_5555_6666_7777);
        chk("miss_we", dcWriteByteWE, 8'hF0);
        ack(1'b1);
        chk("miss_release", releaseStoreQueueHead, 1);
        cyc();
        chk("miss_busy_end", busyInRecovery, 0);

        // Disabled conditional store: released without any write.
        push(32'h5000, 64'h5, 8'hFF, 1'b0, 1'b0);
        commit(2'd1);
        chk("dis_req_t1", dcWriteReq, 0);
        chk("dis_release_t1", releaseStoreQueueHead, 0);
        cyc();
        chk("dis_release_t2", releaseStoreQueueHead, 1);
        chk("dis_req_t2", dcWriteReq, 0);
        cyc();
        chk("dis_busy_t3", busyInRecovery, 0);
        chk("dis_release_t3", releaseStoreQueueHead, 0);

        // Uncachable store: a miss ack still releases, no retry.
        push(32'h6000, 64'h6, 8'h01, 1'b1, 1'b1);
        commit(2'd1);
        wait_req("unc_req", w);
        chk("unc_flag", dcWriteUncachable, 1);
        ack(1'b0);
        chk("unc_release", releaseStoreQueueHead, 1);
        chk("unc_req_low", dcWriteReq, 0);
        cyc();
        chk("unc_busy_end", busyInRecovery, 0);
        chk("unc_no_retry", dcWriteReq, 0);

        // Commit of two during the release cycle nets pending 1 -> 2.
        push(32'h7000, 64'h70, 8'hFF, 1'b1, 1'b0);
        push(32'h7040, 64'h71, 8'hFF, 1'b1, 1'b0);
        push(32'h7080, 64'h72, 8'hFF, 1'b1, 1'b0);
        commit(2'd1);
        wait_req("cdr_req0", w);
        ack(1'b1);
        chk("cdr_release0", releaseStoreQueueHead, 1);
        commit(2'd2);
        for (int j = 1; j < 3; j++) begin
            wait_req("cdr_req", w);
            chk("cdr_addr", dcWriteAddr, 64'h7000 + 64'(j * 64));
            ack(1'b1);
            chk("cdr_release", releaseStoreQueueHead, 1);
            chk("cdr_busy_in_rel", busyInRecovery, 1);
        end
        repeat (3) cyc();
        chk("cdr_busy_end", busyInRecovery, 0);
        chk("cdr_no_extra_req", dcWriteReq, 0);

        // Reset while requesting: everything clears at once, no release afterwards.
        push(32'h8000, 64'h8, 8'hFF, 1'b1, 1'b0);
        commit(2'd1);
        wait_req("rr_req", w);
        #2 rst = 1'b0;
        #1;
        chk("rr_req", dcWriteReq, 0);
        chk("rr_addr", dcWriteAddr, 0);
        chk("rr_we", dcWriteByteWE, 0);
        chk("rr_release", releaseStoreQueueHead, 0);
        chk("rr_busy", busyInRecovery, 0);
        cyc();
        rst = 1'b1;
        repeat (4) cyc();
        chk("rr_req_after", dcWriteReq, 0);
        chk("rr_busy_after", busyInRecovery, 0);
        chk("rr_release_after", releaseStoreQueueHead, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
